// File: rtl/axi_adder_arbiter.sv
// axi_adder_arbiter: round-robin arbiter sharing one 8-bit AXI-Stream adder among NUM_REQ requesters
//
// Ports:
//   clk, rst_n                         clock and synchronous active-low reset
//   s_axis_req_*                       per-requester operand streams, slice i = {op2, op1}
//   m_axis_rsp_*                       per-requester sum streams, slice i = 16-bit sum
//   m_axis_term1_* / m_axis_term2_*    8-bit operand streams to the adder
//   s_axis_sum_*                       16-bit result stream from the adder
//   grant_id                           requester currently owning the adder
//   busy                               high while a transaction is in flight
//
// Configuration: define AXI_ADDER_ARB_FIXED_PRIO_EN to make the lowest-index
// valid requester always win (the rotation pointer stays at 0).
module axi_adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ*16-1:0]  s_axis_req_data,
  input  logic [NUM_REQ-1:0]     s_axis_req_valid,
  output logic [NUM_REQ-1:0]     s_axis_req_ready,
  output logic [NUM_REQ*16-1:0]  m_axis_rsp_data,
  output logic [NUM_REQ-1:0]     m_axis_rsp_valid,
  input  logic [NUM_REQ-1:0]     m_axis_rsp_ready,
  output logic [7:0]             m_axis_term1_data,
  output logic                   m_axis_term1_valid,
  input  logic                   m_axis_term1_ready,
  output logic [7:0]             m_axis_term2_data,
  output logic                   m_axis_term2_valid,
  input  logic                   m_axis_term2_ready,
  input  logic [15:0]            s_axis_sum_data,
  input  logic                   s_axis_sum_valid,
  output logic                   s_axis_sum_ready,
  output logic [IDX_W-1:0]       grant_id,
  output logic                   busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_SUM, RETURN} state_t;
  state_t state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_nxt, win;
  logic found, req_hs, rsp_hs;
  logic [7:0] op1, op2;
  logic t1_v, t2_v;
  logic [15:0] sum;
  // scan downward so the requester closest to rr_ptr (lowest offset) overrides
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (s_axis_req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        win = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
        found = 1'b1;
      end
  end
  assign req_hs = (state == IDLE) && found;
  assign rsp_hs = (state == RETURN) && m_axis_rsp_ready[grant_id];
`ifdef AXI_ADDER_ARB_FIXED_PRIO_EN
  assign rr_nxt = '0;
`else
  assign rr_nxt = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
`endif
  // ISSUE ends once neither operand remains outstanding after this cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = found ? ISSUE : IDLE;
      ISSUE:    state_nxt = ((t1_v && !m_axis_term1_ready) || (t2_v && !m_axis_term2_ready)) ? ISSUE : WAIT_SUM;
      WAIT_SUM: state_nxt = s_axis_sum_valid ? RETURN : WAIT_SUM;
      RETURN:   state_nxt = rsp_hs ? IDLE : RETURN;
      default:  state_nxt = IDLE;
    endcase
  end
  always_comb begin
    s_axis_req_ready = '0;
    m_axis_rsp_valid = '0;
    m_axis_rsp_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_axis_req_ready[i] = req_hs && (win == IDX_W'(i));
      m_axis_rsp_valid[i] = (state == RETURN) && (grant_id == IDX_W'(i));
      m_axis_rsp_data[i*16 +: 16] = m_axis_rsp_valid[i] ? sum : 16'h0;
    end
  end
  assign m_axis_term1_data = op1;
  assign m_axis_term2_data = op2;
  assign m_axis_term1_valid = (state == ISSUE) && t1_v;
  assign m_axis_term2_valid = (state == ISSUE) && t2_v;
  assign s_axis_sum_ready = (state == IDLE) || (state == WAIT_SUM);
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      op1 <= '0;
      op2 <= '0;
      t1_v <= 1'b0;
      t2_v <= 1'b0;
      sum <= '0;
    end else begin
      state <= state_nxt;
      if (req_hs) begin
        grant_id <= win;
        {op2, op1} <= s_axis_req_data[int'(win)*16 +: 16];
      end
      t1_v <= req_hs || (t1_v && !(m_axis_term1_valid && m_axis_term1_ready));
      t2_v <= req_hs || (t2_v && !(m_axis_term2_valid && m_axis_term2_ready));
      if (state == WAIT_SUM && s_axis_sum_valid) sum <= s_axis_sum_data;
      if (rsp_hs) rr_ptr <= rr_nxt;
    end
  end
endmodule

// File: tb/tb_axi_adder_arbiter.sv
// tb_axi_adder_arbiter: randomized and directed self-checking bench against a transaction-level model
module tb_axi_adder_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N*16-1:0] req_data = '0, rsp_data;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '1;
  logic [7:0] t1_data, t2_data;
  logic t1_valid, t2_valid, t1_ready = 1'b1, t2_ready = 1'b1;
  logic [15:0] sum_data = '0;
  logic sum_valid = 1'b0, sum_ready;
  logic [1:0] grant_id;
  logic busy;
  axi_adder_arbiter #(.NUM_REQ(N), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_req_data(req_data), .s_axis_req_valid(req_valid), .s_axis_req_ready(req_ready),
    .m_axis_rsp_data(rsp_data), .m_axis_rsp_valid(rsp_valid), .m_axis_rsp_ready(rsp_ready),
    .m_axis_term1_data(t1_data), .m_axis_term1_valid(t1_valid), .m_axis_term1_ready(t1_ready),
    .m_axis_term2_data(t2_data), .m_axis_term2_valid(t2_valid), .m_axis_term2_ready(t2_ready),
    .s_axis_sum_data(sum_data), .s_axis_sum_valid(sum_valid), .s_axis_sum_ready(sum_ready),
    .grant_id(grant_id), .busy(busy)
  );
  int total = 0, bad = 0;
  int p_req = 0, p_t1 = 100, p_t2 = 100, p_rsp = 100, lat = 0;
  int rr = 0, gid = 0, cnt = 0;
  bit inflight = 0, got_sum = 0, t1_out = 0, t2_out = 0;
  logic [15:0] opd = '0, exp_sum = '0;
  bit h1 = 0, h2 = 0;
  logic [7:0] a1 = '0, a2 = '0;
  int order[$];
  logic [15:0] sums[$];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    int w;
    logic [N-1:0] er, erv;
    logic [N*16-1:0] ed;
    bit rl, rh, h1s, h2s, shs, sg, ohs, esr;
    logic [15:0] osum;
    @(negedge clk);
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && req_valid[(rr + k) % N]) w = (rr + k) % N;
    er = '0;
    if (!inflight && w >= 0) er[w] = 1'b1;
    erv = '0;
    ed = '0;
    if (inflight && got_sum) begin
      erv[gid] = 1'b1;
      ed[gid*16 +: 16] = exp_sum;
    end
    esr = !inflight || (!t1_out && !t2_out && !got_sum);
    check("busy", busy, inflight);
    check("req_ready", req_ready, er);
    check("rsp_valid", rsp_valid, erv);
    check("rsp_data", rsp_data, ed);
    check("t1_valid", t1_valid, t1_out);
    check("t2_valid", t2_valid, t2_out);
    check("sum_ready", sum_ready, esr);
    if (t1_out) check("t1_data", t1_data, opd[7:0]);
    if (t2_out) check("t2_data", t2_data, opd[15:8]);
    if (inflight) check("grant_id", grant_id, gid);
    rl = rst_n;
    rh = rl && !inflight && w >= 0;
    h1s = t1_out && t1_ready;
    h2s = t2_out && t2_ready;
    shs = sum_valid && esr;
    sg = shs && inflight;
    ohs = inflight && got_sum && rsp_ready[gid];
    osum = rsp_data[gid*16 +: 16];
    if (h1s) begin a1 = t1_data; h1 = 1; end
    if (h2s) begin a2 = t2_data; h2 = 1; end
    if ((h1s || h2s) && h1 && h2) cnt = lat;
    @(posedge clk);
    #1;
    if (shs) sum_valid = 1'b0;
    if (h1 && h2 && !sum_valid) begin
      if (cnt == 0) begin
        sum_valid = 1'b1;
        sum_data = {8'h0, a1} + {8'h0, a2};
        h1 = 0;
        h2 = 0;
      end else cnt--;
    end
    if (!rl) begin
      inflight = 0; got_sum = 0; t1_out = 0; t2_out = 0; rr = 0;
    end else begin
      if (rh) begin
        inflight = 1; gid = w; got_sum = 0; t1_out = 1; t2_out = 1;
        opd = req_data[w*16 +: 16];
        exp_sum = {8'h0, opd[15:8]} + {8'h0, opd[7:0]};
        req_valid[w] = 1'b0;
      end
      if (h1s) t1_out = 0;
      if (h2s) t2_out = 0;
      if (sg) got_sum = 1;
      if (ohs) begin
        order.push_back(gid);
        sums.push_back(osum);
        inflight = 0;
        got_sum = 0;
`ifdef AXI_ADDER_ARB_FIXED_PRIO_EN
        rr = 0;
`else
        rr = (gid + 1) % N;
`endif
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] && int'($urandom_range(99)) < p_req) begin
        req_valid[i] = 1'b1;
        req_data[i*16 +: 16] = 16'($urandom);
      end
      rsp_ready[i] = int'($urandom_range(99)) < p_rsp;
    end
    t1_ready = int'($urandom_range(99)) < p_t1;
    t2_ready = int'($urandom_range(99)) < p_t2;
  endtask
  task automatic issue(input int i, input logic [7:0] o1, input logic [7:0] o2);
    req_valid[i] = 1'b1;
    req_data[i*16 +: 16] = {o2, o1};
  endtask
  task automatic drain();
    for (int c = 0; c < 400; c++) begin
      if (!inflight && req_valid == '0 && !h1 && !h2 && !sum_valid) return;
      tick();
    end
    check("drain_timeout", 1, 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    int n0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_t1", {t1_valid, t1_data}, 0);
    check("rst_t2", {t2_valid, t2_data}, 0);
    check("rst_sum_ready", sum_ready, 1);
    issue(2, 8'h7F, 8'h81);
    drain();
    check("single_id", order[$], 2);
    check("single_sum", sums[$], 16'h0100);
    check("single_busy", busy, 0);
    do_reset();
    issue(0, 8'h01, 8'h02);
    issue(1, 8'h10, 8'h20);
    issue(2, 8'hFF, 8'hFF);
    issue(3, 8'h00, 8'h00);
    drain();
    for (int k = 0; k < 4; k++) check("all4_order", order[order.size()-4+k], k);
    check("all4_s0", sums[sums.size()-4], 16'h0003);
    check("all4_s1", sums[sums.size()-3], 16'h0030);
    check("all4_s2", sums[sums.size()-2], 16'h01FE);
    check("all4_s3", sums[sums.size()-1], 16'h0000);
`ifdef AXI_ADDER_ARB_FIXED_PRIO_EN
    issue(0, 8'h05, 8'h06);
    issue(1, 8'h07, 8'h08);
    for (int r = 0; r < 3; r++) begin
      n0 = order.size();
      for (int c = 0; c < 100 && order.size() == n0; c++) tick();
      check("fixed_winner", order[$], 0);
      issue(0, 8'(r), 8'(r + 1));
    end
    drain();
`endif
    t1_ready = 1'b0;
    p_t1 = 0;
    issue(0, 8'h33, 8'h44);
    repeat (5) tick();
    p_t1 = 100;
    drain();
    check("skew_sum", sums[$], 16'h0077);
    rsp_ready = '0;
    p_rsp = 0;
    issue(1, 8'hA0, 8'h0B);
    repeat (8) tick();
    issue(0, 8'h01, 8'h01);
    issue(3, 8'h02, 8'h02);
    repeat (5) tick();
    p_rsp = 100;
    drain();
    check("bp_first", order[order.size()-3], 1);
    check("bp_sum", sums[sums.size()-3], 16'h00AB);
`ifdef AXI_ADDER_ARB_FIXED_PRIO_EN
    check("bp_second", order[order.size()-2], 0);
`else
    check("bp_second", order[order.size()-2], 3);
`endif
    do_reset();
    issue(3, 8'h09, 8'h01);
    drain();
    issue(1, 8'h02, 8'h03);
    drain();
    check("wrap_id", order[$], 1);
    issue(0, 8'h01, 8'h00);
    issue(2, 8'h02, 8'h00);
    issue(3, 8'h03, 8'h00);
    drain();
`ifdef AXI_ADDER_ARB_FIXED_PRIO_EN
    check("wrap_next", order[order.size()-3], 0);
`else
    check("wrap_next", order[order.size()-3], 2);
`endif
    lat = 8;
    issue(2, 8'h11, 8'h22);
    repeat (3) tick();
    do_reset();
    check("rst_mid_grant", grant_id, 0);
    check("rst_mid_busy", busy, 0);
    n0 = order.size();
    drain();
    check("rst_mid_no_rsp", order.size(), n0);
    lat = 0;
    issue(1, 8'h40, 8'h02);
    drain();
    check("rst_mid_next", order.size(), n0 + 1);
    check("rst_mid_sum", sums[$], 16'h0042);
    n0 = order.size();
    p_req = 40; p_t1 = 60; p_t2 = 60; p_rsp = 60;
    for (int c = 0; c < 2000; c++) begin
      lat = int'($urandom_range(3));
      tick();
    end
    p_req = 0; p_t1 = 100; p_t2 = 100; p_rsp = 100;
    drain();
    check("rand_progress", (order.size() - n0) > 50, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
